// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the instruction/data SRAM arbiter.
// Response owner encoding, default starvation bound and memory command layout.
package sram_arbiter_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  strb_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam int STARVE_LIMIT_DEF = 4;

    typedef struct packed {
        logic  en;
        strb_t we;
        word_t addr;
        word_t wdata;
    } mem_cmd_t;

    // A zero limit still needs a one-bit counter to keep the vector legal.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM signal bundle for the arbiter.
// slave = arbiter side, master = requesters plus memory model.
interface sram_arbiter_if;
    import sram_arbiter_pkg::*;

    logic  i_req;
    word_t i_addr;
    logic  i_addr_ok;
    logic  i_data_ok;
    word_t i_rdata;

    logic  d_req;
    logic  d_wr;
    strb_t d_wstrb;
    word_t d_addr;
    word_t d_wdata;
    logic  d_addr_ok;
    logic  d_data_ok;
    word_t d_rdata;

    logic  mem_en;
    strb_t mem_we;
    word_t mem_addr;
    word_t mem_wdata;
    word_t mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_addr_ok, i_data_ok, i_rdata,
        input  d_req, d_wr, d_wstrb, d_addr, d_wdata,
        output d_addr_ok, d_data_ok, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_addr_ok, i_data_ok, i_rdata,
        output d_req, d_wr, d_wstrb, d_addr, d_wdata,
        input  d_addr_ok, d_data_ok, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/sram_arbiter_starve_ctr.sv
// Counts consecutive data grants taken while the inst requester waits.
// Latency: o_starved reflects grants up to the previous edge; no backpressure.
module sram_arbiter_starve_ctr
    import sram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inst_req,
    input  logic i_inst_grant,
    input  logic i_data_grant,
    output logic o_starved
);

    localparam int            CW    = cnt_width(STARVE_LIMIT);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inst_grant || !i_inst_req) begin
            r_cnt <= '0;
        end else if (i_data_grant && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_starved = (r_cnt == LIMIT);

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates inst (read-only) and data requesters onto one single-port SRAM.
// Latency: grant combinational at T, data_ok at T+1; no backpressure, losers hold their request.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    sram_arbiter_if.slave   bus
);

    logic     w_starved;
    logic     w_grant_i;
    logic     w_grant_d;
    mem_cmd_t w_mem;
    logic     w_i_data_ok;
    logic     w_d_data_ok;

    logic     r_resp_vld;
    owner_e   r_resp_owner;

    sram_arbiter_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk          (clk),
        .rst          (rst),
        .i_inst_req   (bus.i_req),
        .i_inst_grant (w_grant_i),
        .i_data_grant (w_grant_d),
        .o_starved    (w_starved)
    );

    // Data normally wins; inst takes over once the starvation bound is reached.
    assign w_grant_i = !rst && bus.i_req && (!bus.d_req || w_starved);
    assign w_grant_d = !rst && bus.d_req && !w_grant_i;

    always_comb begin
        w_mem = '0;
        if (w_grant_i) begin
            w_mem.en   = 1'b1;
            w_mem.addr = bus.i_addr;
        end else if (w_grant_d) begin
            w_mem.en    = 1'b1;
            w_mem.we    = bus.d_wr ? bus.d_wstrb : '0;
            w_mem.addr  = bus.d_addr;
            w_mem.wdata = bus.d_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_vld   <= 1'b0;
            r_resp_owner <= OWN_INST;
        end else begin
            r_resp_vld   <= w_mem.en;
            r_resp_owner <= w_grant_d ? OWN_DATA : OWN_INST;
        end
    end

    assign w_i_data_ok = r_resp_vld && (r_resp_owner == OWN_INST);
    assign w_d_data_ok = r_resp_vld && (r_resp_owner == OWN_DATA);

    assign bus.i_addr_ok = w_grant_i;
    assign bus.d_addr_ok = w_grant_d;
    assign bus.mem_en    = w_mem.en;
    assign bus.mem_we    = w_mem.we;
    assign bus.mem_addr  = w_mem.addr;
    assign bus.mem_wdata = w_mem.wdata;

    assign bus.i_data_ok = w_i_data_ok;
    assign bus.d_data_ok = w_d_data_ok;
    assign bus.i_rdata   = w_i_data_ok ? bus.mem_rdata : '0;
    assign bus.d_rdata   = w_d_data_ok ? bus.mem_rdata : '0;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while an inst request waits.
REQ-002 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-high reset.
REQ-004 Ports i_req in 1, i_addr in 32, i_addr_ok out 1, i_data_ok out 1, i_rdata out 32: inst requester, read-only.
REQ-005 Ports d_req in 1, d_wr in 1, d_wstrb in 4, d_addr in 32, d_wdata in 32, d_addr_ok out 1, d_data_ok out 1, d_rdata out 32: data requester.
REQ-006 Ports mem_en out 1, mem_we out 4, mem_addr out 32, mem_wdata out 32, mem_rdata in 32: shared single-port SRAM, read data valid exactly 1 cycle after mem_en.

Function
REQ-007 Grant is combinational in cycle T: at most one of i_addr_ok / d_addr_ok high; the granted request drives mem_en=1 and mem_addr/mem_we/mem_wdata the same cycle.
REQ-008 Inst grant drives mem_we=0 and mem_wdata=0; data grant drives mem_we = d_wr ? d_wstrb : 0.
REQ-009 No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-010 Priority: data wins when both request, unless starve_cnt == STARVE_LIMIT, in which case inst wins.
REQ-011 starve_cnt (width $clog2(STARVE_LIMIT+1)): increments on each data grant while i_req=1; clears on any inst grant or any cycle with i_req=0; saturates at STARVE_LIMIT.
REQ-012 Response register: resp_vld and resp_owner (0=inst, 1=data) load on every grant, clear when no grant; latency exactly 1 cycle.
REQ-013 In cycle T+1, resp_vld with owner inst -> i_data_ok=1, i_rdata=mem_rdata; owner data -> d_data_ok=1, d_rdata=mem_rdata (write data_ok also pulses, rdata don't-care).
REQ-014 Non-owner rdata outputs SHALL be 0; data_ok pulses are single-cycle per grant.
REQ-015 Back-to-back grants every cycle supported; a grant at T and response for T-1 coexist without stall.
REQ-016 No backpressure on data_ok; requesters must accept responses.
REQ-017 A request without addr_ok is held by the requester; arbiter keeps no request state.

Reset
REQ-018 While rst=1: resp_vld=0, resp_owner=0, starve_cnt=0, all *_addr_ok, *_data_ok, mem_en, mem_we=0 regardless of requests.
REQ-019 Reset asserted mid-transaction discards the pending response: no data_ok in the cycle following reset release.
REQ-020 First grant possible in the first rising edge cycle with rst=0.

Structure
REQ-021 Owner encoding constants (OWN_INST, OWN_DATA) and STARVE_LIMIT default belong in the shared Defines header.
REQ-022 Single flat module; no sub-module required; optional sub-module arb_starve_ctr for REQ-011 counter.

Verification
REQ-023 Inst only: i_req=1, i_addr=0x1C000000, mem preloaded 0x02800413 -> i_addr_ok at T, mem_en=1, mem_we=0; i_data_ok at T+1 with i_rdata=0x02800413, d_data_ok=0.
REQ-024 Data write: d_req=1, d_wr=1, d_wstrb=4'b0011, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_we=4'b0011 at T, d_data_ok at T+1; later read of 0x100 returns 0x0000BEEF (prior 0).
REQ-025 Contention: i_req and d_req held 1 for 12 cycles, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I repeating; each addr_ok matched by owner data_ok next cycle.
REQ-026 Back-to-back: alternate inst/data grants for 8 cycles -> 8 data_ok pulses, correct owner and rdata each cycle, no gaps.
REQ-027 Reset mid-op: grant at T, rst=1 asserted asynchronously before edge T+1 -> no data_ok; outputs 0 during reset; after release, i_req grants immediately.
REQ-028 Idle: no requests 5 cycles -> mem_en=0, all ok signals 0, starve_cnt=0.
